alu_share_arb: RTL and testbench

//  Arbitrates one shared ALU (with its op/funct decode) between two requesters:
//  req 0 = execute stage, req 1 = auxiliary unit (branch target / address adder).

---
 rtl/alu_share_arb.sv | 159 +++++++++++++++
 tb/tb_alu_share_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Shares one ALU between the execute stage (requester 0) and the auxiliary unit (requester 1).
// Round-robin grant, operands registered toward the ALU, and the result is held until its owner accepts it.
module alu_share_arb #(
    parameter int DW  = 16,
    parameter int OPW = 5,
    parameter int FW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DW-1:0]   req_a,
    input  logic [2*DW-1:0]   req_b,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*FW-1:0]   req_funct,
    input  logic              flush,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [OPW-1:0]    alu_op,
    output logic [FW-1:0]     alu_funct,
    input  logic [DW-1:0]     alu_out,
    input  logic              alu_ofl,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_ofl
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             owner_r;
    logic             last_grant_r;
    logic [DW-1:0]    alu_a_r;
    logic [DW-1:0]    alu_b_r;
    logic [OPW-1:0]   alu_op_r;
    logic [FW-1:0]    alu_funct_r;
    logic [1:0]       rsp_valid_r;
    logic [DW-1:0]    rsp_data_r;
    logic             rsp_ofl_r;

    logic [1:0]       valid_s;
    logic             kill_s;
    logic             owner_ack_s;
    logic             accept_win_s;
    logic             grant_any_s;
    logic             grant_idx_s;
    logic [DW-1:0]    sel_a_s;
    logic [DW-1:0]    sel_b_s;
    logic [OPW-1:0]   sel_op_s;
    logic [FW-1:0]    sel_funct_s;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    function automatic logic pick_grant(input logic [1:0] v, input logic last);
        logic g;
        case (v)
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            2'b11:   g = ~last;
            default: g = 1'b0;
        endcase
        return g;
    endfunction

    // flush only ever targets the execute-stage requester, so it masks bit 0 alone.
    assign valid_s     = req_valid & {1'b1, ~flush};
    assign kill_s      = flush & ~owner_r;
    assign owner_ack_s = rsp_ready[owner_r];

    assign sel_a_s     = grant_idx_s ? req_a[2*DW-1 -: DW]      : req_a[DW-1:0];
    assign sel_b_s     = grant_idx_s ? req_b[2*DW-1 -: DW]      : req_b[DW-1:0];
    assign sel_op_s    = grant_idx_s ? req_op[2*OPW-1 -: OPW]   : req_op[OPW-1:0];
    assign sel_funct_s = grant_idx_s ? req_funct[2*FW-1 -: FW]  : req_funct[FW-1:0];

    // Accept window and grant decode; a killed response never doubles as an accept slot.
    always_comb begin
        accept_win_s = 1'b0;
        case (state_r)
            IDLE:    accept_win_s = 1'b1;
            RESP:    accept_win_s = owner_ack_s & ~kill_s;
            default: accept_win_s = 1'b0;
        endcase
        grant_any_s = accept_win_s & (|valid_s);
        grant_idx_s = pick_grant(valid_s, last_grant_r);
        if (grant_any_s) begin
            req_ready = grant_idx_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Arbiter FSM: issue on grant, capture ALU result after one cycle, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            alu_a_r      <= {DW{1'b0}};
            alu_b_r      <= {DW{1'b0}};
            alu_op_r     <= {OPW{1'b0}};
            alu_funct_r  <= {FW{1'b0}};
            rsp_valid_r  <= 2'b00;
            rsp_data_r   <= {DW{1'b0}};
            rsp_ofl_r    <= 1'b0;
        end else begin
            if (grant_any_s) begin
                alu_a_r      <= sel_a_s;
                alu_b_r      <= sel_b_s;
                alu_op_r     <= sel_op_s;
                alu_funct_r  <= sel_funct_s;
                owner_r      <= grant_idx_s;
                last_grant_r <= grant_idx_s;
            end
            case (state_r)
                IDLE: begin
                    state_r <= grant_any_s ? EXEC : IDLE;
                end
                EXEC: begin
                    if (kill_s) begin
                        state_r <= IDLE;
                    end else begin
                        rsp_data_r  <= alu_out;
                        rsp_ofl_r   <= alu_ofl;
                        rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
                        state_r     <= RESP;
                    end
                end
                RESP: begin
                    if (kill_s) begin
                        rsp_valid_r <= 2'b00;
                        state_r     <= IDLE;
                    end else if (owner_ack_s) begin
                        rsp_valid_r <= 2'b00;
                        state_r     <= grant_any_s ? EXEC : IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign alu_funct = alu_funct_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_ofl   = rsp_ofl_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed and randomized bench for alu_share_arb with a behavioural ALU and a
// transaction-level reference of the arbitration and response rules.
module tb_alu_share_arb;

    localparam int DW  = 16;
    localparam int OPW = 5;
    localparam int FW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*DW-1:0]   req_a;
    logic [2*DW-1:0]   req_b;
    logic [2*OPW-1:0]  req_op;
    logic [2*FW-1:0]   req_funct;
    logic              flush;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [OPW-1:0]    alu_op;
    logic [FW-1:0]     alu_funct;
    logic [DW-1:0]     alu_out;
    logic              alu_ofl;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              rsp_ofl;

    int ncmp = 0;
    int nfail = 0;

    // reference: one outstanding transaction at most
    bit          m_busy;
    bit          m_shown;
    bit          m_owner;
    bit          m_last;
    logic [16:0] m_exp;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [1:0]  dut_grants[$];

    alu_share_arb #(.DW(DW), .OPW(OPW), .FW(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_funct(req_funct),
        .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_funct(alu_funct),
        .alu_out(alu_out), .alu_ofl(alu_ofl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ofl(rsp_ofl)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [4:0] op, input logic [1:0] f);
        logic [15:0] r;
        logic        o;
        r = 16'h0000;
        o = 1'b0;
        if (op == 5'b01000 || (op == 5'b11011 && f == 2'b00)) begin
            r = a + b;
            o = (a[15] == b[15]) && (r[15] != a[15]);
        end else if (op == 5'b11011 && f == 2'b01) begin
            r = a - b;
            o = (a[15] != b[15]) && (r[15] != a[15]);
        end else if (op == 5'b11011 && f == 2'b10) begin
            r = a & b;
        end else if (op == 5'b11011) begin
            r = a | b;
        end else begin
            r = a ^ b;
        end
        return {o, r};
    endfunction

    assign {alu_ofl, alu_out} = alu_fn(alu_a, alu_b, alu_op, alu_funct);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] op, input logic [1:0] f);
        req_a[i*DW +: DW]      = a;
        req_b[i*DW +: DW]      = b;
        req_op[i*OPW +: OPW]   = op;
        req_funct[i*FW +: FW]  = f;
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_shown = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
    endtask

    // One clock: inputs are already set just after a falling edge.
    task automatic cycle();
        logic [1:0] v;
        logic [1:0] exp_rdy;
        bit         win;
        bit         g;
        bit         gany;
        bit         kill;
        #1;
        v    = req_valid & {1'b1, ~flush};
        kill = flush && !m_owner;
        win  = !m_busy || (m_shown && rsp_ready[m_owner] && !kill);
        g    = (v == 2'b11) ? ~m_last : v[1];
        gany = win && (v != 2'b00);
        exp_rdy = gany ? (g ? 2'b10 : 2'b01) : 2'b00;
        if (req_ready != 2'b00) dut_grants.push_back(req_ready);
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, (m_busy && m_shown) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
        if (m_busy && m_shown) begin
            chk("rsp_data", rsp_data, m_exp[15:0]);
            chk("rsp_ofl", rsp_ofl, m_exp[16]);
        end
        if (m_busy && !m_shown) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
        end
        @(posedge clk);
        if (m_busy && !m_shown) begin
            if (kill) m_busy = 1'b0;
            else      m_shown = 1'b1;
        end else if (m_busy) begin
            if (kill)                        m_busy = 1'b0;
            else if (rsp_ready[m_owner] && !gany) m_busy = 1'b0;
        end
        if (gany) begin
            m_busy  = 1'b1;
            m_shown = 1'b0;
            m_owner = g;
            m_last  = g;
            m_a     = req_a[g*DW +: DW];
            m_b     = req_b[g*DW +: DW];
            m_exp   = alu_fn(m_a, m_b, req_op[g*OPW +: OPW], req_funct[g*FW +: FW]);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = 2'b00;
        flush     = 1'b0;
        rsp_ready = 2'b11;
        repeat (4) cycle();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; flush = 1'b0; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0; req_funct = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_alu_op", alu_op, 5'h00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data", rsp_data, 16'h0000);
        chk("rst_rsp_ofl", rsp_ofl, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // both continuously valid: strict alternation starting with requester 0
        dut_grants.delete();
        rsp_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            req_valid = 2'b11;
            set_req(0, 16'($urandom), 16'($urandom), 5'b11011, 2'($urandom));
            set_req(1, 16'($urandom), 16'($urandom), 5'b11011, 2'($urandom));
            cycle();
        end
        chk("alt_count", dut_grants.size(), 32'd4);
        if (dut_grants.size() >= 4) begin
            chk("alt_g0", dut_grants[0], 2'b01);
            chk("alt_g1", dut_grants[1], 2'b10);
            chk("alt_g2", dut_grants[2], 2'b01);
            chk("alt_g3", dut_grants[3], 2'b10);
        end
        drain();

        // lone req0 ADD 3+4
        req_valid = 2'b01; rsp_ready = 2'b01;
        set_req(0, 16'h0003, 16'h0004, 5'b11011, 2'b00);
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("add_valid", rsp_valid, 2'b01);
        chk("add_data", rsp_data, 16'h0007);
        cycle();

        // req1 result held while the other requester keeps asking
        req_valid = 2'b10; rsp_ready = 2'b00;
        set_req(1, 16'h1234, 16'h0101, 5'b11011, 2'b11);
        cycle();
        req_valid = 2'b11;
        set_req(0, 16'h00aa, 16'h0055, 5'b11011, 2'b00);
        cycle();
        for (int i = 0; i < 5; i++) begin
            rsp_ready = (i < 2) ? 2'b01 : 2'b00;
            chk("hold_valid", rsp_valid, 2'b10);
            chk("hold_data", rsp_data, 16'h1335);
            cycle();
        end
        req_valid = 2'b00; rsp_ready = 2'b10;
        cycle();
        rsp_ready = 2'b00;
        cycle();
        chk("hold_released", rsp_valid, 2'b00);
        drain();

        // flush in EXEC with owner 0; req1 granted next IDLE cycle
        req_valid = 2'b01; rsp_ready = 2'b00;
        set_req(0, 16'h0010, 16'h0020, 5'b11011, 2'b00);
        set_req(1, 16'h0100, 16'h0001, 5'b11011, 2'b01);
        cycle();
        flush = 1'b1; req_valid = 2'b10;
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_exec_ready", req_ready, 2'b10);
        chk("flush_exec_rsp", rsp_valid, 2'b00);
        cycle();
        drain();

        // flush in RESP with owner 0
        req_valid = 2'b01; rsp_ready = 2'b00;
        cycle();
        req_valid = 2'b00;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_resp", rsp_valid, 2'b00);
        cycle();

        // flush ignored for owner 1
        req_valid = 2'b10;
        cycle();
        req_valid = 2'b00; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_own1", rsp_valid, 2'b10);
        cycle();
        drain();

        // ADDI overflow
        req_valid = 2'b01; rsp_ready = 2'b00;
        set_req(0, 16'h7FFF, 16'h0001, 5'b01000, 2'b00);
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("addi_data", rsp_data, 16'h8000);
        chk("addi_ofl", rsp_ofl, 1'b1);
        cycle();
        drain();

        // async reset while a response is pending
        req_valid = 2'b10; rsp_ready = 2'b00;
        cycle();
        req_valid = 2'b00;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 2'b00);
        chk("arst_data", rsp_data, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("arst_first_grant", req_ready, 2'b01);
        cycle();
        drain();

        // random traffic; flush only paired with rsp_ready low
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            rsp_ready = flush ? 2'b00 : 2'($urandom);
            for (int r = 0; r < 2; r++) begin
                case ($urandom_range(0, 2))
                    0:       set_req(r, 16'($urandom), 16'($urandom), 5'b11011, 2'($urandom));
                    1:       set_req(r, 16'($urandom), 16'($urandom), 5'b01000, 2'($urandom));
                    default: set_req(r, 16'($urandom), 16'($urandom), 5'($urandom), 2'($urandom));
                endcase
            end
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
